// File: rtl/seg7_scan_capture.sv
// Monitors a multiplexed active-high 7-segment bus and rebuilds the BCD value of each digit.
// Outputs register on the accepting edge; the monitor has no backpressure and never stalls the display.
module seg7_scan_capture #(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 seg_a,
  input  logic                 seg_b,
  input  logic                 seg_c,
  input  logic                 seg_d,
  input  logic                 seg_e,
  input  logic                 seg_f,
  input  logic                 seg_g,
  input  logic [NDIG-1:0]      dig_en,
  output logic                 digit_valid,
  output logic [2:0]           digit_idx,
  output logic [3:0]           digit_val,
  output logic [4*NDIG-1:0]    digits,
  output logic                 frame_valid,
  output logic                 frame_err
);

  localparam int         PW      = NDIG + 7;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_ACC = 8'(STABLE_CYCLES - 1);

  typedef enum logic {TRACK, HELD} state_t;

  state_t              state, state_nxt;
  logic   [PW-1:0]     s;
  logic   [PW-1:0]     pat;
  logic   [7:0]        cnt, cnt_nxt;
  logic   [NDIG-1:0]   seen, seen_nxt;
  logic   [4*NDIG-1:0] shadow, shadow_nxt;
  logic                err_acc;
  logic                match, qual, accept, frame_done, invalid;
  logic   [3:0]        ones;
  logic   [2:0]        idx;
  logic   [3:0]        dec_val;
  logic   [6:0]        seg;
  logic   [1:0]        rst_sync;
  logic                rst_int_n;

  // Assertion is immediate; release is retimed onto clk before reaching the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign seg = {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g};
  assign pat = {dig_en, seg};

  function automatic logic [3:0] decode(input logic [6:0] p);
    logic [3:0] v;
    case (p)
      7'b1111110: v = 4'd0;
      7'b0110000: v = 4'd1;
      7'b1101101: v = 4'd2;
      7'b1111001: v = 4'd3;
      7'b0110011: v = 4'd4;
      7'b1011011: v = 4'd5;
      7'b1011111: v = 4'd6;
      7'b1110000: v = 4'd7;
      7'b1111111: v = 4'd8;
      7'b1111011: v = 4'd9;
      default:    v = 4'hF;
    endcase
    return v;
  endfunction

  always_comb begin
    ones = 4'd0;
    idx  = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (dig_en[i]) begin
        ones = ones + 4'd1;
        idx  = 3'(i);
      end
    end
  end

  assign qual    = (ones == 4'd1);
  assign match   = (pat == s);
  assign dec_val = decode(seg);
  assign invalid = (dec_val == 4'hF);
  assign accept  = (state == TRACK) && match && (cnt == CNT_ACC) && qual;

  // Any change of the bus restarts tracking; a dwell is accepted at most once.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!match) begin
      state_nxt = TRACK;
      cnt_nxt   = 8'd0;
    end else begin
      if (accept) state_nxt = HELD;
      if (cnt != CNT_MAX) cnt_nxt = cnt + 8'd1;
    end
  end

  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < NDIG; i++) begin
      if (3'(i) == idx) shadow_nxt[4*i +: 4] = dec_val;
    end
    seen_nxt   = seen | dig_en;
    frame_done = accept && (&seen_nxt);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state <= TRACK;
      s     <= '0;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      s     <= pat;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      seen        <= '0;
      shadow      <= '0;
      err_acc     <= 1'b0;
      digit_valid <= 1'b0;
      digit_idx   <= 3'd0;
      digit_val   <= 4'd0;
      digits      <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      digit_valid <= accept;
      frame_valid <= frame_done;
      if (accept) begin
        digit_idx <= idx;
        digit_val <= dec_val;
        shadow    <= shadow_nxt;
        if (frame_done) begin
          digits    <= shadow_nxt;
          frame_err <= err_acc | invalid;
          seen      <= '0;
          err_acc   <= 1'b0;
        end else begin
          seen    <= seen_nxt;
          err_acc <= err_acc | invalid;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed and randomized bench for seg7_scan_capture against a run-length reference model.
module tb_seg7_scan_capture;

  localparam int NDIG = 4;
  localparam int STAB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  logic [3:0]  dig_en;
  logic        digit_valid, frame_valid, frame_err;
  logic [2:0]  digit_idx;
  logic [3:0]  digit_val;
  logic [15:0] digits;

  int tests = 0;
  int fails = 0;
  int dv_cnt, fv_cnt;

  seg7_scan_capture #(.NDIG(NDIG), .STABLE_CYCLES(STAB)) dut (
    .clk(clk), .rst_n(rst_n),
    .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
    .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g),
    .dig_en(dig_en),
    .digit_valid(digit_valid), .digit_idx(digit_idx), .digit_val(digit_val),
    .digits(digits), .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  logic [6:0] segtab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  // Reference model: counts how many consecutive edges the same bus value has been seen.
  logic [10:0] m_prev;
  int          m_run;
  logic [3:0]  m_sh [4];
  bit          m_seen [4];
  bit          m_err;
  bit          m_dv, m_fv, m_ferr;
  int          m_idx;
  logic [3:0]  m_val;
  logic [15:0] m_digits;

  function automatic logic [3:0] ref_decode(input logic [6:0] p);
    for (int k = 0; k < 10; k++) if (segtab[k] == p) return 4'(k);
    return 4'hF;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_run = 1; m_err = 0;
    m_dv = 0; m_fv = 0; m_ferr = 0; m_idx = 0; m_val = 0; m_digits = '0;
    for (int k = 0; k < 4; k++) begin m_sh[k] = 4'd0; m_seen[k] = 0; end
  endtask

  task automatic model_edge(input logic [3:0] en, input logic [6:0] sg);
    int  n;
    bit  all;
    m_dv = 0; m_fv = 0;
    if ({en, sg} == m_prev) m_run++; else m_run = 1;
    m_prev = {en, sg};
    n = 0;
    for (int k = 0; k < 4; k++) if (en[k]) begin n++; m_idx = k; end
    if (m_run == STAB + 1 && n == 1) begin
      m_dv  = 1;
      m_val = ref_decode(sg);
      m_sh[m_idx]   = m_val;
      m_seen[m_idx] = 1;
      m_err = m_err | (m_val == 4'hF);
      all = 1;
      for (int k = 0; k < 4; k++) all = all & m_seen[k];
      if (all) begin
        m_fv = 1; m_ferr = m_err; m_err = 0;
        m_digits = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
        for (int k = 0; k < 4; k++) m_seen[k] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] en, input logic [6:0] sg);
    dig_en = en;
    {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = sg;
  endtask

  task automatic step(input logic [3:0] en, input logic [6:0] sg);
    drive(en, sg);
    @(posedge clk);
    model_edge(en, sg);
    #1;
    dv_cnt += int'(digit_valid);
    fv_cnt += int'(frame_valid);
    chk("digit_valid", 32'(digit_valid), 32'(m_dv));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("digits", 32'(digits), 32'(m_digits));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
    if (m_dv) begin
      chk("digit_idx", 32'(digit_idx), 32'(m_idx));
      chk("digit_val", 32'(digit_val), 32'(m_val));
    end
  endtask

  task automatic hold(input logic [3:0] en, input logic [6:0] sg, input int n);
    for (int k = 0; k < n; k++) step(en, sg);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dv"}, 32'(digit_valid), 32'd0);
    chk({tag, "_fv"}, 32'(frame_valid), 32'd0);
    chk({tag, "_digits"}, 32'(digits), 32'd0);
    chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
    chk({tag, "_idx"}, 32'(digit_idx), 32'd0);
    chk({tag, "_val"}, 32'(digit_val), 32'd0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    drive(4'b0000, 7'b0);
    #1 chk_zero("reset");
    model_reset();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    hold(4'b0000, 7'b0, 4);
  endtask

  task automatic clr_cnt();
    dv_cnt = 0; fv_cnt = 0;
  endtask

  initial begin
    logic [3:0] en;
    logic [6:0] sg;
    int         r;
    drive(4'b0000, 7'b0);
    model_reset();
    #12 chk_zero("por");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    hold(4'b0000, 7'b0, 4);

    // Ordered scan 1,2,3,4 with blanking gaps.
    clr_cnt();
    for (int d = 0; d < 4; d++) begin
      hold(4'(1 << d), segtab[d+1], 8);
      hold(4'b0000, 7'b0, 2);
    end
    chk("scan_dv_count", 32'(dv_cnt), 32'd4);
    chk("scan_fv_count", 32'(fv_cnt), 32'd1);
    chk("scan_digits", 32'(digits), 32'h4321);
    chk("scan_ferr", 32'(frame_err), 32'd0);

    // Dwell-length boundary: 4 edges no accept, 5 edges accept, 50 edges once.
    clr_cnt(); hold(4'b0001, segtab[1], 4); hold(4'b0000, 7'b0, 1);
    chk("dwell4_dv", 32'(dv_cnt), 32'd0);
    clr_cnt(); hold(4'b0001, segtab[1], 5); hold(4'b0000, 7'b0, 1);
    chk("dwell5_dv", 32'(dv_cnt), 32'd1);
    clr_cnt(); hold(4'b0001, segtab[1], 50); hold(4'b0000, 7'b0, 1);
    chk("dwell50_dv", 32'(dv_cnt), 32'd1);

    // Invalid pattern on digit 2.
    hold(4'b0001, segtab[5], 6); hold(4'b0010, segtab[6], 6);
    hold(4'b0100, 7'b0000001, 6); hold(4'b1000, segtab[7], 6);
    chk("bad_digits", 32'(digits), 32'h7F65);
    chk("bad_ferr", 32'(frame_err), 32'd1);
    for (int d = 0; d < 4; d++) hold(4'(1 << d), segtab[d+1], 6);
    chk("clean_ferr", 32'(frame_err), 32'd0);
    chk("clean_digits", 32'(digits), 32'h4321);

    // Multi-hot never accepted; glitch delays acceptance.
    clr_cnt(); hold(4'b0011, segtab[3], 20); hold(4'b0000, 7'b0, 1);
    chk("multihot_dv", 32'(dv_cnt), 32'd0);
    clr_cnt();
    hold(4'b0001, segtab[3], 2); hold(4'b0001, segtab[8], 1); hold(4'b0001, segtab[3], 4);
    chk("glitch_early_dv", 32'(dv_cnt), 32'd0);
    hold(4'b0001, segtab[3], 1);
    chk("glitch_late_dv", 32'(dv_cnt), 32'd1);
    chk("glitch_val", 32'(digit_val), 32'd3);

    // Digit 0 overwritten before frame completes.
    hold(4'b0000, 7'b0, 2);
    clr_cnt();
    hold(4'b0001, segtab[8], 6); hold(4'b0000, 7'b0, 2);
    for (int d = 1; d < 4; d++) hold(4'(1 << d), segtab[9], 6);
    chk("ovr_fv_count", 32'(fv_cnt), 32'd1);
    chk("ovr_digits", 32'(digits), 32'h9998);

    // Reset mid-frame discards partial progress.
    for (int d = 0; d < 3; d++) hold(4'(1 << d), segtab[d+5], 6);
    hold(4'b1000, segtab[8], 2);
    apply_reset();
    clr_cnt(); hold(4'b1000, segtab[8], 6); hold(4'b0000, 7'b0, 1);
    chk("post_rst_partial_fv", 32'(fv_cnt), 32'd0);
    for (int d = 0; d < 4; d++) hold(4'(1 << d), segtab[d+5], 6);
    chk("post_rst_full_fv", 32'(fv_cnt), 32'd1);
    chk("post_rst_digits", 32'(digits), 32'h8765);

    // Randomized dwells over valid, invalid, blank and multi-hot inputs.
    for (int it = 0; it < 300; it++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      en = 4'b0000;
      else if (r == 1) en = 4'($urandom_range(0, 15));
      else             en = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) sg = 7'($urandom_range(0, 127));
      else                           sg = segtab[$urandom_range(0, 9)];
      hold(en, sg, int'($urandom_range(1, 8)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive-side counterpart of the BCD-to-7-segment decoder: watches a multiplexed, active-high 7-segment bus and its one-hot digit enables, and reconstructs the BCD value of each digit.
- Filters glitches and blanking intervals, then assembles a full frame of NDIG digits.
- Used as a self-checking monitor and loopback receiver behind the display driver.

Parameters:
- NDIG, 4, number of multiplexed digits (2..8).
- STABLE_CYCLES, 4, consecutive matching samples required before a pattern is accepted (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg_a..seg_g  input  1 each  segment lines, active-high, synchronous to clk.
- dig_en  input  NDIG  digit enables, active-high, one-hot when a digit is driven.
- digit_valid  output  1  one-cycle pulse: a digit was accepted.
- digit_idx  output  3  index of the accepted digit.
- digit_val  output  4  decoded value of the accepted digit (4'hF if invalid).
- digits  output  4*NDIG  last complete frame; digit i is at [4i+3:4i].
- frame_valid  output  1  one-cycle pulse: digits updated.
- frame_err  output  1  registered with digits: 1 if any digit in that frame was invalid.

Behaviour:
- Reset (async assert, sync release): all outputs are 0. The sample register, counter, seen mask and shadow are 0. FSM is TRACK.
- Sample register s holds {dig_en, seg_a..seg_g} from the previous edge. Counter cnt is saturating at STABLE_CYCLES.
- Each edge: if the input equals s, cnt increments; otherwise cnt is 0. s always takes the input.
- Qualify: the input is qualifying when dig_en is exactly one-hot. Zero-hot (blanking) or multi-hot inputs are never accepted but still update s and cnt.
- FSM TRACK: on an edge where the input equals s, cnt == STABLE_CYCLES-1, and the input qualifies, the pattern is accepted and the FSM goes to HELD.
  - Net effect: a pattern held across STABLE_CYCLES+1 consecutive rising edges is accepted on the last of them.
- FSM HELD: no further acceptance while the input equals s. Any input change returns the FSM to TRACK with cnt = 0. This gives one acceptance per dwell, however long the dwell.
- Decode, on abcdefg:
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9.
  - Any other pattern gives 4'hF and marks the digit invalid.
- On acceptance, registered on the accept edge:
  - digit_valid = 1; digit_idx = position of the set dig_en bit; digit_val = decoded value.
  - shadow[idx] is written and seen[idx] is set. err_acc |= invalid.
  - If seen[idx] was already set, the shadow is overwritten with the newer value and err_acc keeps its prior errors.
- Frame complete: when the acceptance makes seen all-ones, on the same edge:
  - digits = shadow including the new digit; frame_err = err_acc including the new digit; frame_valid = 1.
  - seen and err_acc clear.
- digits and frame_err hold until the next frame. digit_valid and frame_valid are 0 on all other edges.
- Digit order within a frame is irrelevant; frames may be built from any scan order.
- Reset mid-frame discards partial shadow and seen state. The next frame requires all NDIG digits again.

Test Plan:
- Digits 1,2,3,4 on dig_en 0001,0010,0100,1000, each held 8 cycles, 2 blank cycles (dig_en=0) between -> four digit_valid pulses with idx 0..3, one frame_valid on the 4th acceptance, digits=16'h4321, frame_err=0.
- dig_en=0001, seg=0110000 held exactly 4 edges, then changed -> no digit_valid. Held 5 edges -> digit_valid on the 5th edge with val 1. Held 50 edges -> still exactly one pulse.
- Invalid pattern 0000001 on digit 2 within an otherwise valid scan of 5,6,x,7 -> digit_val=F at idx 2, digits=16'h7F65, frame_err=1. The next clean frame gives frame_err=0.
- dig_en=0011 held 20 cycles -> no acceptance. 1-cycle glitch inside a digit-0 dwell -> counter restarts and acceptance is delayed by the glitch position.
- Digit 0 accepted as 3, then as 8 before the frame completes, then digits 1..3 = 9,9,9 -> digits=16'h9998, single frame_valid.
- Capture digits 0..2, pulse rst_n low mid-dwell -> all outputs 0 immediately. After release, only a full 4-digit scan produces frame_valid.
